// File: rtl/ice40_audio_fb_blk_writer.sv
// Filterbank block-buffer producer: packs the word stream into a circular
// 256-block memory, raises held start requests and answers block read-ready queries.
module ice40_audio_fb_blk_writer #(
  parameter int C_BLK_LEN    = 64,
  parameter int C_FRAME_BLKS = 130,
  parameter int C_HOP_BLKS   = 2,
  parameter int C_RD_SPAN    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_enable,
  input  logic [15:0] i_din,
  input  logic        i_din_vld,
  output logic        o_wr_en,
  output logic [13:0] o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic [7:0]  o_blk_idx,
  output logic        o_start,
  input  logic        i_done,
  input  logic        i_rd_req,
  input  logic [7:0]  i_rd_blk_idx,
  output logic        o_rd_rdy,
  output logic [7:0]  o_fill_cnt,
  output logic [7:0]  o_miss_cnt
);

  localparam logic [5:0] LAST_WORD = 6'(C_BLK_LEN - 1);
  localparam logic [7:0] FRAME_B   = 8'(C_FRAME_BLKS);
  localparam logic [7:0] HOP_B     = 8'(C_HOP_BLKS);
  localparam logic [7:0] HOP_M1    = 8'(C_HOP_BLKS - 1);
  localparam logic [7:0] SPAN_B    = 8'(C_RD_SPAN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_RELEASE
  } state_t;

  state_t      state;
  logic [5:0]  word_cnt;
  logic [7:0]  hop_cnt;
  logic        blk_done;
  logic        accept;
  logic        clear_cnt;
  logic        go_start;
  logic [7:0]  cur_blk;
  logic [7:0]  rd_dist;

  assign accept    = i_din_vld & i_enable;
  assign clear_cnt = !i_enable && (state != S_START);
  assign go_start  = (state == S_FILL) && i_enable &&
                     (o_fill_cnt >= FRAME_B) && (hop_cnt >= HOP_B);
  // A block that has just completed is not yet reflected in o_blk_idx, so the
  // next word must already target the following block to avoid a gap.
  assign cur_blk   = blk_done ? o_blk_idx + 8'd1 : o_blk_idx;
  assign rd_dist   = o_blk_idx - i_rd_blk_idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_blk_idx  <= '0;
      o_fill_cnt <= '0;
      o_miss_cnt <= '0;
      word_cnt   <= '0;
      hop_cnt    <= '0;
      blk_done   <= 1'b0;
    end else begin
      o_wr_en <= accept;
      if (accept) begin
        o_wr_addr <= {cur_blk, word_cnt};
        o_wr_data <= i_din;
      end
      blk_done <= accept && (word_cnt == LAST_WORD);

      if (clear_cnt)
        word_cnt <= '0;
      else if (accept)
        word_cnt <= (word_cnt == LAST_WORD) ? 6'd0 : word_cnt + 6'd1;

      if (blk_done)
        o_blk_idx <= o_blk_idx + 8'd1;

      if (clear_cnt)
        o_fill_cnt <= '0;
      else if (blk_done && (o_fill_cnt != 8'hFF))
        o_fill_cnt <= o_fill_cnt + 8'd1;

      // Hop counting restarts at the start request; a completion landing on the
      // same edge still counts toward the next hop.
      if (clear_cnt)
        hop_cnt <= '0;
      else if (go_start)
        hop_cnt <= blk_done ? 8'd1 : 8'd0;
      else if (blk_done && (hop_cnt != 8'hFF))
        hop_cnt <= hop_cnt + 8'd1;

      if (blk_done && !clear_cnt && (hop_cnt == HOP_M1) && (o_miss_cnt != 8'hFF) &&
          ((state == S_START) || (state == S_RELEASE)))
        o_miss_cnt <= o_miss_cnt + 8'd1;
    end
  end

  // o_start drops on the same edge that sees i_done so the consumer gets a
  // one-edge release; S_RELEASE then guarantees at least one low cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      o_start <= 1'b0;
    end else begin
      o_start <= (state == S_START) && !i_done;
      case (state)
        S_IDLE: begin
          if (i_enable)
            state <= S_FILL;
        end
        S_FILL: begin
          if (!i_enable)
            state <= S_IDLE;
          else if (go_start)
            state <= S_START;
        end
        S_START: begin
          if (i_done)
            state <= S_RELEASE;
        end
        S_RELEASE: begin
          state <= i_enable ? S_FILL : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      o_rd_rdy <= 1'b0;
    else
      o_rd_rdy <= i_rd_req && (rd_dist >= SPAN_B) && (rd_dist <= o_fill_cnt);
  end

endmodule

// File: tb/tb_ice40_audio_fb_blk_writer.sv
// Directed bench for ice40_audio_fb_blk_writer: a small write-path model runs
// every cycle, with table-driven read-ready vectors and hand-checked corner sequences.
module tb_ice40_audio_fb_blk_writer;

  logic        clk;
  logic        resetn;
  logic        i_enable;
  logic [15:0] i_din;
  logic        i_din_vld;
  logic        o_wr_en;
  logic [13:0] o_wr_addr;
  logic [15:0] o_wr_data;
  logic [7:0]  o_blk_idx;
  logic        o_start;
  logic        i_done;
  logic        i_rd_req;
  logic [7:0]  i_rd_blk_idx;
  logic        o_rd_rdy;
  logic [7:0]  o_fill_cnt;
  logic [7:0]  o_miss_cnt;

  ice40_audio_fb_blk_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_enable     (i_enable),
    .i_din        (i_din),
    .i_din_vld    (i_din_vld),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_blk_idx    (o_blk_idx),
    .o_start      (o_start),
    .i_done       (i_done),
    .i_rd_req     (i_rd_req),
    .i_rd_blk_idx (i_rd_blk_idx),
    .o_rd_rdy     (o_rd_rdy),
    .o_fill_cnt   (o_fill_cnt),
    .o_miss_cnt   (o_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int mdl_err = 0;

  logic [7:0] m_blk;
  logic [5:0] m_word;
  logic [7:0] m_fill;
  logic       m_pend;

  typedef struct {
    logic       req;
    logic [7:0] blk;
    logic       exp_rdy;
  } rd_vec_t;

  rd_vec_t rd_vecs[9];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_blk  = '0;
    m_word = '0;
    m_fill = '0;
    m_pend = 1'b0;
  endtask

  // One clock: the model tracks the write address, block index and fill count
  // from the inputs presented before the edge.
  task automatic apply_stimulus();
    logic        acc;
    logic        en_s;
    logic [15:0] din_s;
    acc   = i_din_vld && i_enable;
    en_s  = i_enable;
    din_s = i_din;
    @(posedge clk);
    #1;
    if (m_pend) begin
      m_blk++;
      m_pend = 1'b0;
      if (m_fill != 8'hFF) m_fill++;
    end
    if (!en_s) begin
      m_word = '0;
      m_fill = '0;
    end
    if (o_wr_en !== acc) mdl_err++;
    if (acc) begin
      if (o_wr_addr !== {m_blk, m_word} || o_wr_data !== din_s) mdl_err++;
      if (m_word == 6'd63) begin
        m_word = '0;
        m_pend = 1'b1;
      end else begin
        m_word++;
      end
    end
    if (o_blk_idx !== m_blk || o_fill_cnt !== m_fill) mdl_err++;
  endtask

  task automatic stream(input int n);
    for (int k = 0; k < n; k++) begin
      i_enable  = 1'b1;
      i_din_vld = 1'b1;
      i_din     = 16'($urandom);
      apply_stimulus();
    end
    i_din_vld = 1'b0;
  endtask

  task automatic check_model(input string name);
    check_output(name, 32'(mdl_err), 32'd0);
    mdl_err = 0;
  endtask

  task automatic reset_dut();
    resetn       = 1'b0;
    i_enable     = 1'b0;
    i_din        = '0;
    i_din_vld    = 1'b0;
    i_done       = 1'b0;
    i_rd_req     = 1'b0;
    i_rd_blk_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;
  endtask

  initial begin
    rd_vecs[0] = '{req: 1'b1, blk: 8'd6,   exp_rdy: 1'b1};
    rd_vecs[1] = '{req: 1'b1, blk: 8'd7,   exp_rdy: 1'b0};
    rd_vecs[2] = '{req: 1'b1, blk: 8'd250, exp_rdy: 1'b0};
    rd_vecs[3] = '{req: 1'b1, blk: 8'd9,   exp_rdy: 1'b0};
    rd_vecs[4] = '{req: 1'b1, blk: 8'd0,   exp_rdy: 1'b1};
    rd_vecs[5] = '{req: 1'b1, blk: 8'd255, exp_rdy: 1'b0};
    rd_vecs[6] = '{req: 1'b0, blk: 8'd6,   exp_rdy: 1'b0};
    rd_vecs[7] = '{req: 1'b1, blk: 8'd5,   exp_rdy: 1'b1};
    rd_vecs[8] = '{req: 1'b1, blk: 8'd10,  exp_rdy: 1'b0};

    reset_dut();
    check_output("rst_wr_en",  32'(o_wr_en),    32'd0);
    check_output("rst_addr",   32'(o_wr_addr),  32'd0);
    check_output("rst_blk",    32'(o_blk_idx),  32'd0);
    check_output("rst_start",  32'(o_start),    32'd0);
    check_output("rst_rd_rdy", 32'(o_rd_rdy),   32'd0);
    check_output("rst_fill",   32'(o_fill_cnt), 32'd0);
    check_output("rst_miss",   32'(o_miss_cnt), 32'd0);

    // Continuous stream of one block.
    stream(64);
    check_output("blk0_last_addr", 32'(o_wr_addr), 32'h003F);
    check_output("blk0_idx_hold",  32'(o_blk_idx), 32'd0);
    apply_stimulus();
    check_output("blk0_idx_adv",   32'(o_blk_idx),  32'd1);
    check_output("blk0_fill",      32'(o_fill_cnt), 32'd1);
    check_output("blk0_wr_idle",   32'(o_wr_en),    32'd0);
    check_model("model_stream");

    // First start after 130 blocks, then handshake.
    stream(129 * 64);
    apply_stimulus();
    check_output("fill_130",      32'(o_fill_cnt), 32'd130);
    check_output("start_edge0",   32'(o_start),    32'd0);
    apply_stimulus();
    check_output("start_edge1",   32'(o_start),    32'd0);
    apply_stimulus();
    check_output("start_edge2",   32'(o_start),    32'd1);
    i_done = 1'b1;
    apply_stimulus();
    check_output("done_drop",     32'(o_start),    32'd0);
    i_done = 1'b0;
    apply_stimulus();
    check_output("release_low",   32'(o_start),    32'd0);
    stream(128);
    check_output("hop_wait",      32'(o_start),    32'd0);
    apply_stimulus();
    check_output("fill_132",      32'(o_fill_cnt), 32'd132);
    apply_stimulus();
    check_output("start2_edge1",  32'(o_start),    32'd0);
    apply_stimulus();
    check_output("start2_edge2",  32'(o_start),    32'd1);
    check_model("model_start");

    // Four blocks complete while the start is held.
    stream(256);
    apply_stimulus();
    check_output("miss_once",     32'(o_miss_cnt), 32'd1);
    check_output("start_held",    32'(o_start),    32'd1);
    check_model("model_miss");

    // Asynchronous reset mid-block while the start is high.
    stream(10);
    #2;
    resetn = 1'b0;
    #1;
    check_output("areset_start",  32'(o_start),    32'd0);
    check_output("areset_blk",    32'(o_blk_idx),  32'd0);
    check_output("areset_miss",   32'(o_miss_cnt), 32'd0);
    check_output("areset_addr",   32'(o_wr_addr),  32'd0);
    @(posedge clk);
    #1;
    model_reset();
    resetn = 1'b1;

    // Read-ready table with o_blk_idx = 10 and fill = 10.
    stream(640);
    apply_stimulus();
    check_output("rd_blk10",  32'(o_blk_idx),  32'd10);
    check_output("rd_fill10", 32'(o_fill_cnt), 32'd10);
    for (int v = 0; v < 9; v++) begin
      i_rd_req     = rd_vecs[v].req;
      i_rd_blk_idx = rd_vecs[v].blk;
      apply_stimulus();
      check_output($sformatf("rd_vec%0d", v), 32'(o_rd_rdy), 32'(rd_vecs[v].exp_rdy));
    end
    i_rd_req     = 1'b1;
    i_rd_blk_idx = 8'd7;
    stream(64);
    apply_stimulus();
    check_output("rd_raise_pre",  32'(o_rd_rdy), 32'd0);
    apply_stimulus();
    check_output("rd_raise",      32'(o_rd_rdy), 32'd1);
    i_rd_req = 1'b0;
    apply_stimulus();
    check_output("rd_req_drop",   32'(o_rd_rdy), 32'd0);
    check_model("model_rd");

    // Enable drop at word 30 of block 5.
    reset_dut();
    stream(5 * 64 + 30);
    i_enable  = 1'b0;
    i_din_vld = 1'b1;
    apply_stimulus();
    check_output("en_drop_wr",    32'(o_wr_en),    32'd0);
    apply_stimulus();
    check_output("en_drop_fill",  32'(o_fill_cnt), 32'd0);
    check_output("en_drop_blk",   32'(o_blk_idx),  32'd5);
    i_enable  = 1'b1;
    i_din_vld = 1'b1;
    i_din     = 16'hA5C3;
    apply_stimulus();
    check_output("reen_wr",       32'(o_wr_en),    32'd1);
    check_output("reen_addr",     32'(o_wr_addr),  32'h0140);
    check_output("reen_data",     32'(o_wr_data),  32'hA5C3);
    i_din_vld = 1'b0;
    check_model("model_enable");

    // Wrap from block 255 to block 0 and saturate the fill count.
    stream(63 + 250 * 64);
    check_output("wrap_last_addr", 32'(o_wr_addr), 32'h3FFF);
    check_output("wrap_blk255",    32'(o_blk_idx), 32'd255);
    stream(1);
    check_output("wrap_addr0",     32'(o_wr_addr), 32'h0000);
    check_output("wrap_blk0",      32'(o_blk_idx), 32'd0);
    stream(63 + 4 * 64);
    apply_stimulus();
    check_output("fill_sat",       32'(o_fill_cnt), 32'd255);
    check_output("wrap_miss",      32'(o_miss_cnt), 32'd1);
    check_output("wrap_start",     32'(o_start),    32'd1);
    check_model("model_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
